// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a sequential clear engine.
// Two write ports (port 1 wins on a same-index collision) and NRD combinational
// read ports. Entry 0 is hardwired to zero. After reset or a clr_req pulse, the
// clear engine zeroes entries 1..NREGS-1, one per cycle. ready is held low
// until that sweep completes.
// Optional feature: define REGFILE_BYPASS_EN so that a read sees same-cycle
// write data. Port 1 is preferred over port 0.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                clr_req,
    output logic                ready,
    input  logic                wen0,
    input  logic [IW-1:0]       rd0_idx,
    input  logic [XLEN-1:0]     rd0_wdata,
    input  logic                wen1,
    input  logic [IW-1:0]       rd1_idx,
    input  logic [XLEN-1:0]     rd1_wdata,
    input  logic [NRD*IW-1:0]   rs_idx,
    output logic [NRD*XLEN-1:0] rs_data
);

    typedef enum logic {S_CLEAR, S_RUN} state_e;

    localparam logic [IW-1:0] PTR_FIRST = IW'(1);
    localparam logic [IW-1:0] PTR_LAST  = IW'(NREGS - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [XLEN-1:0]   mem_q [1:NREGS-1];
    logic              wr0_ok, wr1_ok;

    // A write is architecturally valid only for a non-zero, in-range index.
    // The array must also be out of the clear sweep.
    assign ready  = (state_q == S_RUN);
    assign wr0_ok = ready && wen0 && (rd0_idx != '0) && (32'(rd0_idx) < NREGS);
    assign wr1_ok = ready && wen1 && (rd1_idx != '0) && (32'(rd1_idx) < NREGS);

    // Clear-engine state and sweep pointer register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= PTR_FIRST;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic. clr_req always restarts the sweep at entry 1.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_req) begin
                    clr_ptr_d = PTR_FIRST;
                end else if (clr_ptr_q == PTR_LAST) begin
                    state_d   = S_RUN;
                    clr_ptr_d = PTR_FIRST;
                end else begin
                    clr_ptr_d = clr_ptr_q + IW'(1);
                end
            end
            S_RUN: begin
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = PTR_FIRST;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_ptr_d = PTR_FIRST;
            end
        endcase
    end

    // Array update. The sweep zeroes the entry under the pointer. Otherwise
    // port 1 takes precedence over port 0. The array has no reset value of
    // its own, so nothing is written while reset is asserted.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            for (int e = 1; e < NREGS; e++) begin
                if (state_q == S_CLEAR && clr_ptr_q == IW'(e))
                    mem_q[e] <= '0;
                else if (wr1_ok && rd1_idx == IW'(e))
                    mem_q[e] <= rd1_wdata;
                else if (wr0_ok && rd0_idx == IW'(e))
                    mem_q[e] <= rd0_wdata;
            end
        end
    end

    // Independent read ports. Index 0, an out-of-range index, or not-ready
    // all yield zero, because no entry matches or the mux is gated off.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] val;

        assign idx = rs_idx[k*IW +: IW];

        // Read mux, with optional same-cycle write forwarding.
        always_comb begin
            val = '0;
            if (ready) begin
                for (int e = 1; e < NREGS; e++) begin
                    if (idx == IW'(e))
                        val = mem_q[e];
                end
`ifdef REGFILE_BYPASS_EN
                if (wr0_ok && rd0_idx == idx)
                    val = rd0_wdata;
                if (wr1_ok && rd1_idx == idx)
                    val = rd1_wdata;
`endif
            end
        end

        assign rs_data[k*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// The main instance uses NREGS=32 and NRD=2. A second instance uses NREGS=24
// and NRD=1 to exercise a non-power-of-two depth.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int IW   = 5;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              clr_req = 1'b0;
    logic              ready;
    logic              wen0 = 1'b0, wen1 = 1'b0;
    logic [IW-1:0]     rd0_idx = '0, rd1_idx = '0;
    logic [XLEN-1:0]   rd0_wdata = '0, rd1_wdata = '0;
    logic [NRD*IW-1:0] rs_idx = '0;
    logic [NRD*XLEN-1:0] rs_data;

    logic              ready24;
    logic              w24_wen0 = 1'b0, w24_wen1 = 1'b0;
    logic [IW-1:0]     w24_idx0 = '0, w24_idx1 = '0;
    logic [XLEN-1:0]   w24_wd0 = '0, w24_wd1 = '0;
    logic [IW-1:0]     rs24_idx = '0;
    logic [XLEN-1:0]   rs24_data;

    int nvec = 0;
    int nerr = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .clr_req(clr_req), .ready(ready),
        .wen0(wen0), .rd0_idx(rd0_idx), .rd0_wdata(rd0_wdata),
        .wen1(wen1), .rd1_idx(rd1_idx), .rd1_wdata(rd1_wdata),
        .rs_idx(rs_idx), .rs_data(rs_data)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(24), .NRD(1)) u_dut24 (
        .ACLK(ACLK), .ARESETn(ARESETn), .clr_req(1'b0), .ready(ready24),
        .wen0(w24_wen0), .rd0_idx(w24_idx0), .rd0_wdata(w24_wd0),
        .wen1(w24_wen1), .rd1_idx(w24_idx1), .rd1_wdata(w24_wd1),
        .rs_idx(rs24_idx), .rs_data(rs24_data)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [XLEN-1:0] port(input int k);
        return rs_data[k*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0;
        wen1 = 1'b0;
        clr_req = 1'b0;
        w24_wen0 = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        ARESETn = 1'b0;
        rs_idx = {5'd3, 5'd0};
        repeat (3) tick();
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b expected 0", ready); end
        nvec++; if (rs_data !== '0) begin nerr++; $display("FAIL reset_rs_data: got %h expected 0", rs_data); end
        nvec++; if (ready24 !== 1'b0) begin nerr++; $display("FAIL reset_ready24: got %b expected 0", ready24); end
        ARESETn = 1'b1;
        wait_ready(cnt);
        nvec++; if (cnt != 31) begin nerr++; $display("FAIL sweep_len: got %0d expected 31", cnt); end
        nvec++; if (ready24 !== 1'b1) begin nerr++; $display("FAIL ready24_after: got %b expected 1", ready24); end
        for (int i = 0; i < 32; i++) begin
            rs_idx = {5'(31 - i), 5'(i)};
            #1;
            nvec++;
            if (rs_data !== '0) begin nerr++; $display("FAIL post_sweep_zero idx %0d: got %h expected 0", i, rs_data); end
        end
    endtask

    task automatic test_write_read();
        wen0 = 1'b1; rd0_idx = 5'd5; rd0_wdata = 32'hDEADBEEF;
        tick();
        idle();
        rs_idx = {5'd0, 5'd5};
        #1;
        nvec++; if (port(0) !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_rd5: got %h expected deadbeef", port(0)); end
        nvec++; if (port(1) !== 32'h0) begin nerr++; $display("FAIL rd_idx0: got %h expected 0", port(1)); end
        wen1 = 1'b1; rd1_idx = 5'd31; rd1_wdata = 32'h31313131;
        tick();
        idle();
        rs_idx = {5'd31, 5'd5};
        #1;
        nvec++; if (port(1) !== 32'h31313131) begin nerr++; $display("FAIL wr_rd31: got %h expected 31313131", port(1)); end
        nvec++; if (port(0) !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd5_kept: got %h expected deadbeef", port(0)); end
    endtask

    task automatic test_priority();
        wen0 = 1'b1; rd0_idx = 5'd7; rd0_wdata = 32'h11;
        wen1 = 1'b1; rd1_idx = 5'd7; rd1_wdata = 32'h22;
        tick();
        rd0_idx = 5'd3; rd0_wdata = 32'h33;
        rd1_idx = 5'd4; rd1_wdata = 32'h44;
        tick();
        idle();
        rs_idx = {5'd7, 5'd7};
        #1;
        nvec++; if (port(0) !== 32'h22) begin nerr++; $display("FAIL prio_p0: got %h expected 22", port(0)); end
        nvec++; if (port(1) !== 32'h22) begin nerr++; $display("FAIL prio_p1: got %h expected 22", port(1)); end
        rs_idx = {5'd4, 5'd3};
        #1;
        nvec++; if (port(0) !== 32'h33) begin nerr++; $display("FAIL dual_wr3: got %h expected 33", port(0)); end
        nvec++; if (port(1) !== 32'h44) begin nerr++; $display("FAIL dual_wr4: got %h expected 44", port(1)); end
    endtask

    task automatic test_idx0_oob();
        logic [XLEN-1:0] exp;
        wen0 = 1'b1; rd0_idx = 5'd0; rd0_wdata = 32'hFFFFFFFF;
        wen1 = 1'b1; rd1_idx = 5'd0; rd1_wdata = 32'hFFFFFFFF;
        tick();
        wen1 = 1'b0;
        rd0_idx = 5'd6; rd0_wdata = 32'h66;
        tick();
        idle();
        rs_idx = {5'd6, 5'd0};
        #1;
        nvec++; if (port(0) !== 32'h0) begin nerr++; $display("FAIL wr_idx0: got %h expected 0", port(0)); end
        nvec++; if (port(1) !== 32'h66) begin nerr++; $display("FAIL wr_idx6: got %h expected 66", port(1)); end
        w24_wen0 = 1'b1; w24_idx0 = 5'd5;  w24_wd0 = 32'h55; tick();
        w24_idx0 = 5'd23; w24_wd0 = 32'h23; tick();
        w24_idx0 = 5'd30; w24_wd0 = 32'hEEEE; tick();
        idle();
        for (int e = 0; e < 32; e++) begin
            rs24_idx = 5'(e);
            #1;
            exp = (e == 5) ? 32'h55 : (e == 23) ? 32'h23 : 32'h0;
            nvec++;
            if (rs24_data !== exp) begin nerr++; $display("FAIL n24_idx %0d: got %h expected %h", e, rs24_data, exp); end
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp9, exp10;
        wen0 = 1'b1; rd0_idx = 5'd9; rd0_wdata = 32'h1234;
        tick();
        wen0 = 1'b1; rd0_idx = 5'd9; rd0_wdata = 32'h1;
        wen1 = 1'b1; rd1_idx = 5'd9; rd1_wdata = 32'hA5A5;
        rs_idx = {5'd9, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp9 = 32'hA5A5;
`else
        exp9 = 32'h1234;
`endif
        nvec++; if (port(1) !== exp9) begin nerr++; $display("FAIL byp_p1: got %h expected %h", port(1), exp9); end
        nvec++; if (port(0) !== exp9) begin nerr++; $display("FAIL byp_p0: got %h expected %h", port(0), exp9); end
        tick();
        wen1 = 1'b0;
        wen0 = 1'b1; rd0_idx = 5'd10; rd0_wdata = 32'h0F0F;
        rs_idx = {5'd0, 5'd10};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp10 = 32'h0F0F;
`else
        exp10 = 32'h0;
`endif
        nvec++; if (port(0) !== exp10) begin nerr++; $display("FAIL byp_wen0: got %h expected %h", port(0), exp10); end
        tick();
        wen0 = 1'b1; rd0_idx = 5'd0; rd0_wdata = 32'h77;
        rs_idx = {5'd10, 5'd0};
        #1;
        nvec++; if (port(0) !== 32'h0) begin nerr++; $display("FAIL byp_idx0: got %h expected 0", port(0)); end
        tick();
        idle();
        rs_idx = {5'd10, 5'd9};
        #1;
        nvec++; if (port(0) !== 32'hA5A5) begin nerr++; $display("FAIL byp_next9: got %h expected a5a5", port(0)); end
        nvec++; if (port(1) !== 32'h0F0F) begin nerr++; $display("FAIL byp_next10: got %h expected 0f0f", port(1)); end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 1; i < 32; i++) begin
            wen0 = 1'b1; rd0_idx = 5'(i); rd0_wdata = 32'h1000 + 32'(i);
            tick();
        end
        idle();
        rs_idx = {5'd31, 5'd1};
        #1;
        nvec++; if (port(0) !== 32'h1001) begin nerr++; $display("FAIL fill_1: got %h expected 1001", port(0)); end
        nvec++; if (port(1) !== 32'h101F) begin nerr++; $display("FAIL fill_31: got %h expected 101f", port(1)); end
        clr_req = 1'b1;
        wen0 = 1'b1; rd0_idx = 5'd2; rd0_wdata = 32'h2222;
        tick();
        idle();
        #1;
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL clr_ready: got %b expected 0", ready); end
        nvec++; if (rs_data !== '0) begin nerr++; $display("FAIL clr_forced0: got %h expected 0", rs_data); end
        cnt = 0;
        while (!ready && cnt < 100) begin
            wen0 = (cnt == 10); rd0_idx = 5'd1; rd0_wdata = 32'hBAD;
            tick();
            cnt++;
        end
        idle();
        nvec++; if (cnt != 31) begin nerr++; $display("FAIL clr_len: got %0d expected 31", cnt); end
        for (int i = 1; i < 32; i++) begin
            rs_idx = {5'(i), 5'(i)};
            #1;
            nvec++;
            if (rs_data !== '0) begin nerr++; $display("FAIL clr_zero idx %0d: got %h expected 0", i, rs_data); end
        end
    endtask

    task automatic test_clear_restart();
        int cnt;
        wen0 = 1'b1; rd0_idx = 5'd4; rd0_wdata = 32'h44;
        tick();
        idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_ready(cnt);
        nvec++; if (cnt != 31) begin nerr++; $display("FAIL restart_len: got %0d expected 31", cnt); end
        rs_idx = {5'd0, 5'd4};
        #1;
        nvec++; if (port(0) !== 32'h0) begin nerr++; $display("FAIL restart_zero4: got %h expected 0", port(0)); end
    endtask

    task automatic test_reset_run();
        int cnt;
        wen1 = 1'b1; rd1_idx = 5'd6; rd1_wdata = 32'h66;
        tick();
        idle();
        rs_idx = {5'd6, 5'd6};
        #1;
        nvec++; if (port(1) !== 32'h66) begin nerr++; $display("FAIL run_wr6: got %h expected 66", port(1)); end
        ARESETn = 1'b0;
        tick();
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL rst_run_ready: got %b expected 0", ready); end
        nvec++; if (rs_data !== '0) begin nerr++; $display("FAIL rst_run_rs: got %h expected 0", rs_data); end
        ARESETn = 1'b1;
        wait_ready(cnt);
        nvec++; if (cnt != 31) begin nerr++; $display("FAIL rst_run_len: got %0d expected 31", cnt); end
        #1;
        nvec++; if (port(0) !== 32'h0) begin nerr++; $display("FAIL rst_run_zero6: got %h expected 0", port(0)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_idx0_oob();
        test_bypass();
        test_clear();
        test_clear_restart();
        test_reset_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
